// File: rtl/hkspi_pkg.sv
// Shared definitions for the housekeeping SPI register-bus sequencer.
package hkspi_pkg;

    // Sequencer states: idle, write access in flight, read access in flight
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } hk_state_t;

    localparam int         HK_ADDR_W   = 8;
    localparam int         HK_DATA_W   = 8;
    localparam int         HK_CNT_W    = 8;
    localparam logic [7:0] HK_ERR_DATA = 8'hFF;

endpackage

// File: rtl/hkspi_strobe_sync.sv
// Brings one SCK-domain strobe into the clk domain and turns its rising
// edge into a single-cycle pulse.
module hkspi_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic csb_reset,
    input  logic strobe,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;

    // Synchronizer chain plus one flop holding the previous synchronized level
    always_ff @(posedge clk or posedge csb_reset) begin
        if (csb_reset) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], strobe};
            edge_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_reg[SYNC_STAGES-1] & ~edge_reg;

endmodule

// File: rtl/hkspi_reg_sequencer.sv
// Bridges housekeeping SPI read/write strobes onto a single-beat req/ack
// register bus, holds read data for SPI readback, bounds every access with
// a timeout and flags strobes that arrive while an access is in flight.
module hkspi_reg_sequencer
    import hkspi_pkg::*;
#(
    parameter int                ADDR_W      = HK_ADDR_W,
    parameter int                DATA_W      = HK_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter int                TIMEOUT     = 15,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(HK_ERR_DATA)
) (
    input  logic              clk,
    input  logic              csb_reset,
    input  logic              spi_rdstb,
    input  logic              spi_wrstb,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              err,
    output logic              overrun
);

    // Strobe events: bit 0 = read, bit 1 = write
    logic [1:0] strobe_in;
    logic [1:0] strobe_ev;
    logic       rd_ev;
    logic       wr_ev;

    assign strobe_in = {spi_wrstb, spi_rdstb};
    assign rd_ev     = strobe_ev[0];
    assign wr_ev     = strobe_ev[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            hkspi_strobe_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk       (clk),
                .csb_reset (csb_reset),
                .strobe    (strobe_in[gi]),
                .pulse     (strobe_ev[gi])
            );
        end
    endgenerate

    hk_state_t             state_reg;
    hk_state_t             state_next;
    logic [HK_CNT_W-1:0]   cnt_reg;
    logic                  rd_pend_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic                  err_reg;
    logic                  overrun_reg;

    logic active;       // an access is on the bus this cycle
    logic timeout;      // abort cycle; the request is still presented here
    logic finish;       // access ends at the next edge (ack or abort)
    logic accept;       // event taken from IDLE, captures address/data
    logic pend_late;    // read strobe arriving during a write becomes pending
    logic pend_eff;     // pending read including one arriving this cycle
    logic drop_ev;      // event discarded as an overrun

    assign active    = (state_reg != ST_IDLE);
    // The counter reaches TIMEOUT after that many ack-less cycles; an ack in
    // this cycle still completes the access normally.
    assign timeout   = active && (cnt_reg == HK_CNT_W'(TIMEOUT));
    assign finish    = active && (bus_ack || timeout);
    assign accept    = (state_reg == ST_IDLE) && (wr_ev || rd_ev);
    assign pend_late = (state_reg == ST_WR) && rd_ev && !rd_pend_reg;
    assign pend_eff  = rd_pend_reg || pend_late;
    assign drop_ev   = active && (wr_ev || (rd_ev && !pend_late));

    // State register
    always_ff @(posedge clk or posedge csb_reset) begin
        if (csb_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: writes go first, a pending read follows without idling
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (wr_ev) begin
                    state_next = ST_WR;
                end else if (rd_ev) begin
                    state_next = ST_RD;
                end
            end
            ST_WR: begin
                if (finish) begin
                    state_next = pend_eff ? ST_RD : ST_IDLE;
                end
            end
            ST_RD: begin
                if (finish) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus-facing outputs decoded from the state
    always_comb begin
        bus_req = (state_reg != ST_IDLE);
        bus_we  = (state_reg == ST_WR);
        busy    = (state_reg != ST_IDLE) || rd_pend_reg;
    end

    // Datapath: capture, timeout counter, pending read, readback and flags
    always_ff @(posedge clk or posedge csb_reset) begin
        if (csb_reset) begin
            cnt_reg     <= '0;
            rd_pend_reg <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg  <= spi_addr;
                wdata_reg <= spi_wdata;
            end

            // Restart on every entry into an access state, including WR->RD
            if (state_next == ST_IDLE || state_next != state_reg) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + HK_CNT_W'(1);
            end

            unique case (state_reg)
                ST_IDLE: rd_pend_reg <= wr_ev && rd_ev;
                ST_WR:   rd_pend_reg <= finish ? 1'b0 : pend_eff;
                default: rd_pend_reg <= rd_pend_reg;
            endcase

            if (state_reg == ST_RD) begin
                if (bus_ack) begin
                    rdata_reg <= bus_rdata;
                end else if (timeout) begin
                    rdata_reg <= ERR_DATA;
                end
            end

            if (timeout && !bus_ack) begin
                err_reg <= 1'b1;
            end

            if (drop_ev) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign spi_rdata = rdata_reg;
    assign err       = err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_hkspi_reg_sequencer.sv
// Self-checking bench for hkspi_reg_sequencer: directed vector table,
// hand-written multi-cycle sequences and randomized operations checked
// against a transaction-level reference model.
module tb_hkspi_reg_sequencer;

    localparam int SYNC = 2;
    localparam int TMO  = 15;

    logic       clk;
    logic       csb_reset;
    logic       spi_rdstb;
    logic       spi_wrstb;
    logic [7:0] spi_addr;
    logic [7:0] spi_wdata;
    logic [7:0] spi_rdata;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic       busy;
    logic       err;
    logic       overrun;

    hkspi_reg_sequencer #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO),
        .ERR_DATA    (8'hFF)
    ) dut (
        .clk       (clk),
        .csb_reset (csb_reset),
        .spi_rdstb (spi_rdstb),
        .spi_wrstb (spi_wrstb),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_rdata (spi_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .err       (err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One observed bus access
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         len;
        logic       gap;
    } bus_t;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         wdly;
        int         rdly;
        logic [7:0] rval;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    bus_t       obs[$];
    int         wr_dly;
    int         rd_dly;
    logic [7:0] rd_val;
    int         n_checks;
    int         n_fail;
    logic       m_ovr;

    // Bus target: acks after the configured number of request cycles
    // (-1 = never) and logs every access it sees.
    initial begin
        bus_t t;
        int   req_cyc;
        int   dly;
        logic prev_req;
        logic prev_ack;
        logic prev_we;
        bus_ack  = 1'b0;
        bus_rdata = 8'h00;
        req_cyc  = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_we  = 1'b0;
        forever begin
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 8'($urandom);
            if (csb_reset || !bus_req) begin
                req_cyc  = 0;
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (!prev_req || prev_ack || (bus_we != prev_we)) begin
                    t.we    = bus_we;
                    t.addr  = bus_addr;
                    t.wdata = bus_wdata;
                    t.len   = 0;
                    t.gap   = !prev_req;
                    obs.push_back(t);
                    req_cyc = 0;
                end
                t = obs[obs.size()-1];
                t.len++;
                obs[obs.size()-1] = t;
                dly = bus_we ? wr_dly : rd_dly;
                if (req_cyc == dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd_val;
                end
                prev_ack = bus_ack;
                prev_we  = bus_we;
                prev_req = 1'b1;
                req_cyc++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rules: request length for a given ack delay
    function automatic int exp_len(input int dly);
        return (dly < 0 || dly > TMO) ? TMO + 1 : dly + 1;
    endfunction

    function automatic bit timed_out(input int dly);
        return (dly < 0 || dly > TMO);
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_entry(input string tag, input int idx, input logic we,
                               input logic [7:0] addr, input logic [7:0] wdata,
                               input int len, input logic gap);
        if (idx < obs.size()) begin
            check({tag, "_we"},   {31'd0, obs[idx].we}, {31'd0, we});
            check({tag, "_addr"}, {24'd0, obs[idx].addr}, {24'd0, addr});
            if (we) check({tag, "_wdata"}, {24'd0, obs[idx].wdata}, {24'd0, wdata});
            check({tag, "_len"},  obs[idx].len, len);
            check({tag, "_gap"},  {31'd0, obs[idx].gap}, {31'd0, gap});
        end
    endtask

    // Issue one SPI operation (write, read or both) and check the outcome
    task automatic run_op(input string tag, input bit wr, input bit rd,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          input int wdly, input int rdly, input logic [7:0] rval,
                          input logic [7:0] exp_rdata, input bit exp_err);
        int lat;
        int nexp;
        lat = -1;
        obs.delete();
        wr_dly    = wdly;
        rd_dly    = rdly;
        rd_val    = rval;
        spi_addr  = addr;
        spi_wdata = wdata;
        spi_wrstb = wr;
        spi_rdstb = rd;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (bus_req && lat < 0) lat = n;
            if (n == 4) begin
                spi_wrstb = 1'b0;
                spi_rdstb = 1'b0;
            end
        end
        wait_idle();
        nexp = int'(wr) + int'(rd);
        check({tag, "_latency"}, lat, SYNC + 1);
        check({tag, "_nbus"}, obs.size(), nexp);
        if (wr) check_entry({tag, "_w"}, 0, 1'b1, addr, wdata, exp_len(wdly), 1'b1);
        if (rd) check_entry({tag, "_r"}, wr ? 1 : 0, 1'b0, addr, 8'h00, exp_len(rdly), !wr);
        check({tag, "_rdata"}, {24'd0, spi_rdata}, {24'd0, exp_rdata});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
        check({tag, "_req_low"}, {31'd0, bus_req}, 32'd0);
        $display("op %-8s wr=%0b rd=%0b addr=%02h wdata=%02h wdly=%0d rdly=%0d nbus=%0d rdata=%02h err=%0b",
                 tag, wr, rd, addr, wdata, wdly, rdly, obs.size(), spi_rdata, err);
    endtask

    function automatic int rand_dly();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 9) return -1;
        if (r == 8) return TMO;
        return r;
    endfunction

    vec_t vecs[7];

    initial begin
        logic [7:0] m_rdata;
        bit         m_err;
        n_checks  = 0;
        n_fail    = 0;
        m_ovr     = 1'b0;
        wr_dly    = -1;
        rd_dly    = -1;
        rd_val    = 8'h00;
        csb_reset = 1'b1;
        spi_rdstb = 1'b0;
        spi_wrstb = 1'b0;
        spi_addr  = 8'h00;
        spi_wdata = 8'h00;

        //           wr rd addr   wdata  wdly rdly rval   rdata  err
        vecs[0] = '{1, 0, 8'h12, 8'hA5, 2,   0,   8'h00, 8'h00, 0};
        vecs[1] = '{0, 1, 8'h08, 8'h00, 0,   0,   8'h3C, 8'h3C, 0};
        vecs[2] = '{1, 1, 8'h20, 8'h5A, 1,   0,   8'h77, 8'h77, 0};
        vecs[3] = '{0, 1, 8'h30, 8'h00, 0,   TMO, 8'h99, 8'h99, 0};
        vecs[4] = '{0, 1, 8'h40, 8'h00, 0,   -1,  8'h00, 8'hFF, 1};
        vecs[5] = '{1, 0, 8'h50, 8'h0F, 0,   0,   8'h00, 8'hFF, 1};
        vecs[6] = '{1, 1, 8'h60, 8'hE1, -1,  1,   8'h11, 8'h11, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",     {31'd0, bus_req}, 32'd0);
        check("rst_we",      {31'd0, bus_we}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_err",     {31'd0, err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rdata",   {24'd0, spi_rdata}, 32'd0);
        csb_reset = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr,
                   vecs[i].wdata, vecs[i].wdly, vecs[i].rdly, vecs[i].rval,
                   vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Read strobe arriving mid-write becomes a pending read to the same address
        obs.delete();
        wr_dly    = 6;
        rd_dly    = 1;
        rd_val    = 8'hC3;
        spi_addr  = 8'h33;
        spi_wdata = 8'h66;
        spi_wrstb = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 4) begin
                spi_wrstb = 1'b0;
                spi_rdstb = 1'b1;
            end
            if (n == 7) spi_rdstb = 1'b0;
        end
        wait_idle();
        check("late_nbus", obs.size(), 2);
        check_entry("late_w", 0, 1'b1, 8'h33, 8'h66, 7, 1'b1);
        check_entry("late_r", 1, 1'b0, 8'h33, 8'h00, 2, 1'b0);
        check("late_rdata", {24'd0, spi_rdata}, 32'h0000_00C3);
        check("late_overrun", {31'd0, overrun}, 32'd0);
        $display("op late_rd  nbus=%0d rdata=%02h overrun=%0b", obs.size(), spi_rdata, overrun);

        // Second write strobe while a write is in flight is dropped
        obs.delete();
        wr_dly    = 8;
        spi_addr  = 8'h71;
        spi_wdata = 8'h17;
        spi_wrstb = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 2) spi_wrstb = 1'b0;
            if (n == 4) begin
                spi_addr  = 8'h72;
                spi_wdata = 8'h27;
                spi_wrstb = 1'b1;
            end
            if (n == 6) spi_wrstb = 1'b0;
        end
        wait_idle();
        m_ovr = 1'b1;
        check("ovr_nbus", obs.size(), 1);
        check_entry("ovr_w", 0, 1'b1, 8'h71, 8'h17, 9, 1'b1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_bus_addr", {24'd0, bus_addr}, 32'h0000_0071);
        check("ovr_err_kept", {31'd0, err}, 32'd1);
        $display("op overrun  nbus=%0d overrun=%0b bus_addr=%02h", obs.size(), overrun, bus_addr);

        // Asynchronous reset in the middle of a read
        obs.delete();
        rd_dly    = -1;
        spi_addr  = 8'h44;
        spi_rdstb = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 3) spi_rdstb = 1'b0;
        end
        check("mid_rd_req", {31'd0, bus_req}, 32'd1);
        #2 csb_reset = 1'b1;
        #1;
        check("arst_req",     {31'd0, bus_req}, 32'd0);
        check("arst_busy",    {31'd0, busy}, 32'd0);
        check("arst_err",     {31'd0, err}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        check("arst_rdata",   {24'd0, spi_rdata}, 32'd0);
        $display("op reset    req=%0b busy=%0b err=%0b overrun=%0b rdata=%02h",
                 bus_req, busy, err, overrun, spi_rdata);
        @(negedge clk);
        csb_reset = 1'b0;
        m_ovr     = 1'b0;
        @(negedge clk);
        run_op("post_rst", 1'b1, 1'b0, 8'h45, 8'h54, 1, 0, 8'h00, 8'h00, 1'b0);

        // Randomized operations against the transaction-level model
        m_rdata = 8'h00;
        m_err   = 1'b0;
        for (int i = 0; i < 24; i++) begin
            int         kind;
            bit         wr;
            bit         rd;
            int         wdly;
            int         rdly;
            logic [7:0] addr;
            logic [7:0] wdata;
            logic [7:0] rval;
            kind  = int'($urandom_range(0, 2));
            wr    = (kind != 1);
            rd    = (kind != 0);
            wdly  = rand_dly();
            rdly  = rand_dly();
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            rval  = 8'($urandom);
            if (rd) m_rdata = timed_out(rdly) ? 8'hFF : rval;
            if ((wr && timed_out(wdly)) || (rd && timed_out(rdly))) m_err = 1'b1;
            run_op($sformatf("rnd%0d", i), wr, rd, addr, wdata, wdly, rdly, rval, m_rdata, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
